// File: rtl/tlb_inv_engine.sv
// rtl/tlb_inv_engine.sv - INVTLB responder: walks every TLB entry and strobes per-entry clears.
// Optional: define INVTLB_FAST_CLEAR_ALL_EN to replace the op 0/1 walk with a one-cycle clr_all.
module tlb_inv_engine #(
    parameter int TLBNUM = 32,
    parameter int IDX_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inv_en,
    input  logic [4:0]       inv_op,
    input  logic [9:0]       inv_asid,
    input  logic [18:0]      inv_vpn,
    output logic             busy,
    output logic             done,
    output logic             ine,
    output logic [IDX_W-1:0] rd_index,
    input  logic             rd_e,
    input  logic             rd_g,
    input  logic [9:0]       rd_asid,
    input  logic [18:0]      rd_vppn,
    input  logic [5:0]       rd_ps,
`ifdef INVTLB_FAST_CLEAR_ALL_EN
    output logic             clr_all,
`endif
    output logic             clr_en,
    output logic [IDX_W-1:0] clr_index
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WALK,
        ST_DONE,
        ST_FAST
    } state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [4:0]        op_q;
    logic [9:0]        asid_q;
    logic [18:0]       vpn_q;
    logic              busy_q;
    logic              done_q;
    logic              ine_q;
    logic              clr_all_q;

    logic              vmatch;
    logic              amatch;
    logic              entry_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            op_q      <= '0;
            asid_q    <= '0;
            vpn_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ine_q     <= 1'b0;
            clr_all_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            ine_q     <= 1'b0;
            clr_all_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (inv_en) begin
                        if (inv_op > 5'd6) begin
                            ine_q <= 1'b1;
                        end else begin
                            op_q   <= inv_op;
                            asid_q <= inv_asid;
                            vpn_q  <= inv_vpn;
                            idx_q  <= '0;
                            busy_q <= 1'b1;
`ifdef INVTLB_FAST_CLEAR_ALL_EN
                            if (inv_op <= 5'd1) begin
                                state_q   <= ST_FAST;
                                clr_all_q <= 1'b1;
                            end else
`endif
                            state_q <= ST_WALK;
                        end
                    end
                end
                ST_WALK: begin
                    // Index parks on the last entry; only a fresh accept resets it.
                    if (idx_q == IDX_W'(TLBNUM - 1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_FAST: begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        vmatch = 1'b0;
        if (rd_ps == 6'd12) begin
            vmatch = (rd_vppn == vpn_q);
        end else if (rd_ps == 6'd21) begin
            vmatch = (rd_vppn[18:9] == vpn_q[18:9]);
        end
        amatch = (rd_asid == asid_q);
        case (op_q)
            5'd0, 5'd1: entry_match = 1'b1;
            5'd2:       entry_match = rd_g;
            5'd3:       entry_match = ~rd_g;
            5'd4:       entry_match = ~rd_g & amatch;
            5'd5:       entry_match = ~rd_g & amatch & vmatch;
            5'd6:       entry_match = (rd_g | amatch) & vmatch;
            default:    entry_match = 1'b0;
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign ine       = ine_q;
    assign rd_index  = idx_q;
    assign clr_index = idx_q;
    assign clr_en    = (state_q == ST_WALK) & rd_e & entry_match;
`ifdef INVTLB_FAST_CLEAR_ALL_EN
    assign clr_all   = clr_all_q;
`else
    logic unused_clr_all;
    assign unused_clr_all = clr_all_q;
`endif

endmodule

// File: tb/tb_tlb_inv_engine.sv
// tb/tb_tlb_inv_engine.sv - scoreboard bench for tlb_inv_engine with a behavioural TLB table.
// Optional: define INVTLB_FAST_CLEAR_ALL_EN to check the clr_all variant.
module tb_tlb_inv_engine;

    localparam int TLBNUM = 32;
    localparam int IDX_W  = 5;
    localparam int K_CLR  = 0;
    localparam int K_DONE = 1;
    localparam int K_INE  = 2;
    localparam int K_ALL  = 3;
`ifdef INVTLB_FAST_CLEAR_ALL_EN
    localparam logic [4:0] RST_OP = 5'd2;
`else
    localparam logic [4:0] RST_OP = 5'd0;
`endif

    typedef struct {
        int cyc;
        int kind;
        int idx;
    } evt_t;

    logic             clk;
    logic             rst_n;
    logic             inv_en;
    logic [4:0]       inv_op;
    logic [9:0]       inv_asid;
    logic [18:0]      inv_vpn;
    logic             busy;
    logic             done;
    logic             ine;
    logic [IDX_W-1:0] rd_index;
    logic             rd_e;
    logic             rd_g;
    logic [9:0]       rd_asid;
    logic [18:0]      rd_vppn;
    logic [5:0]       rd_ps;
    logic             clr_en;
    logic [IDX_W-1:0] clr_index;
`ifdef INVTLB_FAST_CLEAR_ALL_EN
    logic             clr_all;
`else
    logic             clr_all;
    assign clr_all = 1'b0;
`endif

    logic        tb_e    [TLBNUM];
    logic        tb_g    [TLBNUM];
    logic [9:0]  tb_asid [TLBNUM];
    logic [18:0] tb_vppn [TLBNUM];
    logic [5:0]  tb_ps   [TLBNUM];

    evt_t exp_q[$];
    int   cyc;
    int   busy_lo;
    int   busy_hi;
    int   n_checks;
    int   n_fail;

    tlb_inv_engine #(.TLBNUM(TLBNUM), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inv_en    (inv_en),
        .inv_op    (inv_op),
        .inv_asid  (inv_asid),
        .inv_vpn   (inv_vpn),
        .busy      (busy),
        .done      (done),
        .ine       (ine),
        .rd_index  (rd_index),
        .rd_e      (rd_e),
        .rd_g      (rd_g),
        .rd_asid   (rd_asid),
        .rd_vppn   (rd_vppn),
        .rd_ps     (rd_ps),
`ifdef INVTLB_FAST_CLEAR_ALL_EN
        .clr_all   (clr_all),
`endif
        .clr_en    (clr_en),
        .clr_index (clr_index)
    );

    assign rd_e    = tb_e[rd_index];
    assign rd_g    = tb_g[rd_index];
    assign rd_asid = tb_asid[rd_index];
    assign rd_vppn = tb_vppn[rd_index];
    assign rd_ps   = tb_ps[rd_index];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit model_match(int i, logic [4:0] op, logic [9:0] asid, logic [18:0] vpn);
        bit v;
        bit a;
        bit r;
        v = 1'b0;
        if (tb_ps[i] == 6'd12) v = (tb_vppn[i] == vpn);
        if (tb_ps[i] == 6'd21) v = (tb_vppn[i][18:9] == vpn[18:9]);
        a = (tb_asid[i] == asid);
        case (op)
            5'd0, 5'd1: r = 1'b1;
            5'd2:       r = tb_g[i];
            5'd3:       r = !tb_g[i];
            5'd4:       r = !tb_g[i] && a;
            5'd5:       r = !tb_g[i] && a && v;
            5'd6:       r = (tb_g[i] || a) && v;
            default:    r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic void check_evt(int kind, int idx);
        evt_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event got kind=%0d idx=%0d cyc=%0d, expected none", kind, idx, cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.idx != idx || e.cyc != cyc) begin
            n_fail++;
            $display("FAIL event got kind=%0d idx=%0d cyc=%0d, expected kind=%0d idx=%0d cyc=%0d",
                     kind, idx, cyc, e.kind, e.idx, e.cyc);
        end
    endfunction

    // Monitor: the only process that compares and steps the counters.
    always @(negedge clk) begin
        if (!rst_n) begin
            n_checks++;
            if (busy || done || ine || clr_en || clr_all || rd_index != 0 || clr_index != 0) begin
                n_fail++;
                $display("FAIL reset_outputs got busy=%0b done=%0b ine=%0b clr_en=%0b clr_all=%0b rd_index=%0d clr_index=%0d, expected all 0",
                         busy, done, ine, clr_en, clr_all, rd_index, clr_index);
            end
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_event got nothing by cyc=%0d, expected kind=%0d idx=%0d cyc=%0d",
                         cyc, exp_q[0].kind, exp_q[0].idx, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            n_checks++;
            if (busy !== (cyc >= busy_lo && cyc <= busy_hi)) begin
                n_fail++;
                $display("FAIL busy got %0b at cyc=%0d, expected %0b", busy, cyc, (cyc >= busy_lo && cyc <= busy_hi));
            end
            if (clr_en) begin
                check_evt(K_CLR, int'(clr_index));
                n_checks++;
                if (clr_index != rd_index) begin
                    n_fail++;
                    $display("FAIL clr_index got %0d, expected rd_index %0d", clr_index, rd_index);
                end
            end
            if (done) check_evt(K_DONE, 0);
            if (ine) check_evt(K_INE, 0);
            if (clr_all) check_evt(K_ALL, 0);
        end
    end

    task automatic push(int c, int k, int i);
        evt_t e;
        e.cyc  = c;
        e.kind = k;
        e.idx  = i;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; cycle 0 is the current cycle, accept happens at the next posedge.
    task automatic issue(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] vpn,
                         input int n_walk, input bit exp_done, output int t0);
        t0 = cyc;
        if (op > 5'd6) begin
            push(t0 + 1, K_INE, 0);
`ifdef INVTLB_FAST_CLEAR_ALL_EN
        end else if (op <= 5'd1) begin
            push(t0 + 1, K_ALL, 0);
            push(t0 + 2, K_DONE, 0);
            busy_lo = t0 + 1;
            busy_hi = t0 + 2;
`endif
        end else begin
            for (int i = 0; i < n_walk; i++) begin
                if (tb_e[i] && model_match(i, op, asid, vpn)) push(t0 + 1 + i, K_CLR, i);
            end
            if (exp_done) push(t0 + TLBNUM + 1, K_DONE, 0);
            busy_lo = t0 + 1;
            busy_hi = t0 + TLBNUM + 1;
        end
        inv_en   = 1'b1;
        inv_op   = op;
        inv_asid = asid;
        inv_vpn  = vpn;
        @(negedge clk);
        inv_en   = 1'b0;
        inv_op   = 5'd0;
        inv_asid = 10'h3FF;
        inv_vpn  = 19'h7FFFF;
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_table();
        for (int i = 0; i < TLBNUM; i++) begin
            tb_e[i]    = 1'b0;
            tb_g[i]    = 1'b0;
            tb_asid[i] = 10'h000;
            tb_vppn[i] = 19'h00000;
            tb_ps[i]   = 6'd12;
        end
    endtask

    initial begin
        int t0;
        n_checks = 0;
        n_fail   = 0;
        busy_lo  = 1;
        busy_hi  = 0;
        rst_n    = 1'b0;
        inv_en   = 1'b0;
        inv_op   = 5'd0;
        inv_asid = 10'd0;
        inv_vpn  = 19'd0;
        clear_table();
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // op 0 over a fully populated table
        for (int i = 0; i < TLBNUM; i++) begin
            tb_e[i] = 1'b1;
            tb_asid[i] = 10'(i);
            tb_vppn[i] = 19'(i * 3);
        end
        issue(5'd0, 10'h000, 19'h00000, TLBNUM, 1'b1, t0);
        idle(TLBNUM + 3);

        // op 5: only entry 3 matches fully
        clear_table();
        tb_e[3] = 1'b1; tb_asid[3] = 10'h012; tb_vppn[3] = 19'h01234;
        tb_e[7] = 1'b1; tb_asid[7] = 10'h012; tb_vppn[7] = 19'h01234; tb_g[7] = 1'b1;
        tb_e[9] = 1'b1; tb_asid[9] = 10'h013; tb_vppn[9] = 19'h01234;
        tb_asid[11] = 10'h012; tb_vppn[11] = 19'h01234;
        tb_e[12] = 1'b1; tb_asid[12] = 10'h012; tb_vppn[12] = 19'h01234; tb_ps[12] = 6'd13;
        push(cyc + 4, K_CLR, 3);
        exp_q.delete();
        issue(5'd5, 10'h012, 19'h01234, TLBNUM, 1'b1, t0);
        idle(TLBNUM + 3);

        // op 6: huge-page compare uses only VPPN[18:9]
        clear_table();
        tb_e[5] = 1'b1; tb_g[5] = 1'b1; tb_ps[5] = 6'd21; tb_vppn[5] = 19'h7FFFF; tb_asid[5] = 10'h1AA;
        issue(5'd6, 10'h012, 19'h7FE00, TLBNUM, 1'b1, t0);
        idle(TLBNUM + 3);
        tb_ps[5] = 6'd12;
        issue(5'd6, 10'h012, 19'h7FE00, TLBNUM, 1'b1, t0);
        idle(TLBNUM + 3);

        // illegal op codes
        issue(5'd7, 10'h000, 19'h00000, TLBNUM, 1'b1, t0);
        idle(3);
        issue(5'd31, 10'h000, 19'h00000, TLBNUM, 1'b1, t0);
        idle(3);

        // op 4 on a mixed table with a second request mid-walk
        for (int i = 0; i < TLBNUM; i++) begin
            tb_e[i]    = (i % 4) != 3;
            tb_g[i]    = i[0];
            tb_asid[i] = (i % 3 == 0) ? 10'h055 : 10'h0AA;
            tb_vppn[i] = 19'(i);
            tb_ps[i]   = 6'd12;
        end
        issue(5'd4, 10'h055, 19'h00000, TLBNUM, 1'b1, t0);
        while (cyc < t0 + 10) @(negedge clk);
        inv_en   = 1'b1;
        inv_op   = 5'd0;
        inv_asid = 10'h0AA;
        @(negedge clk);
        inv_en   = 1'b0;
        idle(TLBNUM);

        // op 3 / op 2 on the same table
        issue(5'd3, 10'h000, 19'h00000, TLBNUM, 1'b1, t0);
        idle(TLBNUM + 3);
        issue(5'd2, 10'h000, 19'h00000, TLBNUM, 1'b1, t0);
        idle(TLBNUM + 3);

        // reset in cycle 11 of a walk: only entries 0..9 get cleared
        for (int i = 0; i < TLBNUM; i++) begin
            tb_e[i] = 1'b1;
            tb_g[i] = 1'b1;
        end
        issue(RST_OP, 10'h000, 19'h00000, 10, 1'b0, t0);
        do begin
            @(posedge clk);
            #1;
        end while (cyc != t0 + 11);
        rst_n   = 1'b0;
        busy_hi = 0;
        idle(3);
        rst_n = 1'b1;
        idle(1);
        for (int i = 0; i < TLBNUM; i++) tb_g[i] = (i % 5) == 0;
        issue(5'd3, 10'h000, 19'h00000, TLBNUM, 1'b1, t0);
        idle(TLBNUM + 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
